// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit per clock, logical or arithmetic, Done pulse on completion.
// Latency Shamt+1 edges from the Start edge; Start is ignored while Busy (no abort except reset).
module shift_right_seq #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Source,
  input  logic [CNTW-1:0]  Shamt,
  input  logic             Arith,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNTW-1:0]  r_cnt;
  logic             r_arith;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             w_accept;
  logic             w_fill;

  // A new operation can only be taken when not mid-shift; DONE accepts for back-to-back use.
  assign w_accept = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_fill   = r_arith & r_result[WIDTH-1];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_next = (Shamt != '0) ? S_SHIFT : S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_next = (r_cnt == CNTW'(1)) ? S_DONE : S_SHIFT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      S_SHIFT: Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_arith  <= 1'b0;
    end else if (w_accept) begin
      r_result <= Source;
      r_cnt    <= Shamt;
      r_arith  <= Arith;
      r_carry  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_carry  <= r_result[0];
      r_result <= {w_fill, r_result[WIDTH-1:1]};
      r_cnt    <= r_cnt - CNTW'(1);
    end
  end

  assign Result   = r_result;
  assign CarryOut = r_carry;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed-vector bench for shift_right_seq: inputs driven and outputs sampled on falling edges.
module tb_shift_right_seq;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic [7:0] Source;
  logic [2:0] Shamt;
  logic       Arith;
  logic [7:0] Result;
  logic       CarryOut;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  shift_right_seq #(.WIDTH(8), .CNTW(3)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Source   (Source),
    .Shamt    (Shamt),
    .Arith    (Arith),
    .Result   (Result),
    .CarryOut (CarryOut),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Called at a falling edge; presents Start for one rising edge and watches until Done.
  // lat counts falling edges after the start edge up to the Done cycle (-1 on timeout).
  task automatic run_op(input logic [7:0] src, input logic [2:0] sh, input logic ar,
                        output int lat, output int busy_n, output int overlap);
    lat = -1;
    busy_n = 0;
    overlap = 0;
    Start = 1'b1;
    Source = src;
    Shamt = sh;
    Arith = ar;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (i == 1) Start = 1'b0;
      if (Busy) busy_n++;
      if (Busy && Done) overlap++;
      if (Done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Start = 1'b0;
    Source = 8'h00;
    Shamt = 3'd0;
    Arith = 1'b0;
    #12;
    checks++;
    if ({Result, CarryOut, Busy, Done} !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs: got Result=%h Carry=%b Busy=%b Done=%b, want 00 0 0 0",
               Result, CarryOut, Busy, Done);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Result, CarryOut, Busy, Done} !== 11'h000) begin
      errors++;
      $display("FAIL idle_after_reset: got Result=%h Carry=%b Busy=%b Done=%b, want 00 0 0 0",
               Result, CarryOut, Busy, Done);
    end
  endtask

  task automatic test_logical();
    int lat, bn, ov;
    run_op(8'hB4, 3'd3, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 4 || bn !== 3 || ov !== 0) begin
      errors++;
      $display("FAIL logical_timing: got lat=%0d busy=%0d overlap=%0d, want 4 3 0", lat, bn, ov);
    end
    checks++;
    if (Result !== 8'h16 || CarryOut !== 1'b1) begin
      errors++;
      $display("FAIL logical_result: got %h/%b, want 16/1", Result, CarryOut);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (Result !== 8'h16 || CarryOut !== 1'b1 || Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL logical_hold: got %h/%b Done=%b Busy=%b, want 16/1 0 0",
               Result, CarryOut, Done, Busy);
    end
  endtask

  task automatic test_arith();
    int lat, bn, ov;
    run_op(8'hB4, 3'd3, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 4 || Result !== 8'hF6 || CarryOut !== 1'b1) begin
      errors++;
      $display("FAIL arith_b4_3: got lat=%0d %h/%b, want 4 F6/1", lat, Result, CarryOut);
    end
    @(negedge Clk);
  endtask

  task automatic test_shift7();
    int lat, bn, ov;
    run_op(8'h80, 3'd7, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 8 || bn !== 7 || Result !== 8'hFF || CarryOut !== 1'b0) begin
      errors++;
      $display("FAIL arith_80_7: got lat=%0d busy=%0d %h/%b, want 8 7 FF/0", lat, bn, Result, CarryOut);
    end
    @(negedge Clk);
    run_op(8'h80, 3'd7, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 8 || Result !== 8'h01 || CarryOut !== 1'b0) begin
      errors++;
      $display("FAIL logical_80_7: got lat=%0d %h/%b, want 8 01/0", lat, Result, CarryOut);
    end
    @(negedge Clk);
  endtask

  task automatic test_zero();
    int lat, bn, ov;
    run_op(8'h5A, 3'd0, 1'b1, lat, bn, ov);
    checks++;
    if (lat !== 1 || bn !== 0) begin
      errors++;
      $display("FAIL zero_timing: got lat=%0d busy=%0d, want 1 0", lat, bn);
    end
    checks++;
    if (Result !== 8'h5A || CarryOut !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: got %h/%b, want 5A/0", Result, CarryOut);
    end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse: got Done=%b, want 0", Done);
    end
  endtask

  task automatic test_interference();
    int lat = -1;
    Start = 1'b1;
    Source = 8'h40;
    Shamt = 3'd2;
    Arith = 1'b0;
    @(negedge Clk);
    Start = 1'b1;
    Source = 8'hFF;
    Shamt = 3'd7;
    Arith = 1'b1;
    for (int i = 2; i <= 20; i++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 3 || Result !== 8'h10 || CarryOut !== 1'b0) begin
      errors++;
      $display("FAIL interference: got lat=%0d %h/%b, want 3 10/0", lat, Result, CarryOut);
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int lat, bn, ov;
    run_op(8'hB4, 3'd3, 1'b0, lat, bn, ov);
    run_op(8'h03, 3'd1, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 2 || bn !== 1 || ov !== 0) begin
      errors++;
      $display("FAIL b2b_timing: got lat=%0d busy=%0d overlap=%0d, want 2 1 0", lat, bn, ov);
    end
    checks++;
    if (Result !== 8'h01 || CarryOut !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: got %h/%b, want 01/1", Result, CarryOut);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int lat, bn, ov;
    Start = 1'b1;
    Source = 8'hB4;
    Shamt = 3'd7;
    Arith = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({Result, CarryOut, Busy, Done} !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid_async: got Result=%h Carry=%b Busy=%b Done=%b, want 00 0 0 0",
               Result, CarryOut, Busy, Done);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_idle: got Busy=%b Done=%b Result=%h, want 0 0 00", Busy, Done, Result);
    end
    run_op(8'h03, 3'd1, 1'b0, lat, bn, ov);
    checks++;
    if (lat !== 2 || Result !== 8'h01 || CarryOut !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_restart: got lat=%0d %h/%b, want 2 01/1", lat, Result, CarryOut);
    end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_shift7();
    test_zero();
    test_interference();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
